// File: rtl/prng_fifo_streamer.sv
// Galois-LFSR word generator feeding a first-word-fall-through FIFO drained over valid/ready.
// Supports single, counted-burst and continuous generation, reseed in IDLE, and flush.
module prng_fifo_streamer #(
   parameter int                    DATA_WIDTH      = 4,
   parameter int                    LFSR_WIDTH      = 8,
   parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS       = 8'hB8,
   parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = 8'h01,
   parameter int                    FIFO_DEPTH      = 16,
   parameter int                    BURST_LEN_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [1:0]                      mode,
   input  logic                            start,
   input  logic                            stop,
   input  logic [BURST_LEN_WIDTH-1:0]      burst_len,
   input  logic                            seed_load,
   input  logic [LFSR_WIDTH-1:0]           seed_in,
   input  logic                            flush,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     level,
   output logic                            empty,
   output logic                            full,
   output logic                            busy,
   output logic                            done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [LFSR_WIDTH-1:0] SEED_INIT =
      (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SINGLE = 2'd1,
      ST_BURST  = 2'd2,
      ST_CONT   = 2'd3
   } state_t;

   // Runs DATA_WIDTH Galois steps; returns {next_state, word}, word bit i is the output of step i.
   function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] lfsr_advance(
      input logic [LFSR_WIDTH-1:0] cur
   );
      logic [LFSR_WIDTH-1:0] s;
      logic [DATA_WIDTH-1:0] w;
      logic                  o;
      s = cur;
      w = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         o    = s[0];
         w[i] = o;
         s    = (s >> 1) ^ (o ? LFSR_TAPS : {LFSR_WIDTH{1'b0}});
      end
      return {s, w};
   endfunction

   state_t                       state_r;
   logic [LFSR_WIDTH-1:0]        lfsr_r;
   logic [BURST_LEN_WIDTH-1:0]   remaining_r;
   logic                         done_r;
   logic [PW-1:0]                wr_ptr_r;
   logic [PW-1:0]                rd_ptr_r;
   logic [DATA_WIDTH-1:0]        mem_r [FIFO_DEPTH];

   logic                         gen_s;
   logic                         pop_s;
   logic                         full_s;
   logic                         empty_s;
   logic [PW-1:0]                level_s;
   logic [LFSR_WIDTH-1:0]        lfsr_next_s;
   logic [DATA_WIDTH-1:0]        word_s;

   assign {lfsr_next_s, word_s} = lfsr_advance(lfsr_r);
   assign level_s  = wr_ptr_r - rd_ptr_r;
   assign empty_s  = (level_s == PW'(0));
   assign full_s   = (level_s == PW'(FIFO_DEPTH));
   assign gen_s    = (state_r != ST_IDLE) & ~full_s & ~flush;
   assign pop_s    = ~empty_s & out_ready & ~flush;

   // Head word is forced to zero while empty so uninitialised storage never leaks out.
   assign out_data  = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
   assign out_valid = ~empty_s;
   assign level     = level_s;
   assign empty     = empty_s;
   assign full      = full_s;
   assign busy      = (state_r != ST_IDLE);
   assign done      = done_r;

   // Control FSM, LFSR stepping/reseed and the completion pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         lfsr_r      <= SEED_INIT;
         remaining_r <= '0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (gen_s) begin
            lfsr_r <= lfsr_next_s;
         end else if ((state_r == ST_IDLE) && seed_load) begin
            lfsr_r <= (seed_in == '0) ? LFSR_WIDTH'(1) : seed_in;
         end else begin
            lfsr_r <= lfsr_r;
         end

         if (stop) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start) begin
                     case (mode)
                        2'd0: state_r <= ST_SINGLE;
                        2'd1: begin
                           if (burst_len != '0) begin
                              state_r     <= ST_BURST;
                              remaining_r <= burst_len;
                           end
                        end
                        2'd2: state_r <= ST_CONT;
                        default: state_r <= ST_IDLE;
                     endcase
                  end
               end
               ST_SINGLE: begin
                  if (gen_s) begin
                     state_r <= ST_IDLE;
                     done_r  <= 1'b1;
                  end
               end
               ST_BURST: begin
                  if (gen_s) begin
                     remaining_r <= remaining_r - BURST_LEN_WIDTH'(1);
                     if (remaining_r == BURST_LEN_WIDTH'(1)) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                     end
                  end
               end
               ST_CONT: state_r <= ST_CONT;
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   // FIFO pointers; flush clears them and suppresses that cycle's push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (gen_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (gen_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= word_s;
      end
   end

endmodule

// File: tb/tb_prng_fifo_streamer.sv
// Self-checking bench for prng_fifo_streamer: directed table, hand sequences and random
// stimulus compared every cycle against a queue-based reference model.
module tb_prng_fifo_streamer;

   localparam int DW    = 4;
   localparam int LW    = 8;
   localparam int DEPTH = 16;
   localparam int BLW   = 4;
   localparam int PW    = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [1:0]      mode;
   logic            start, stop, seed_load, flush, out_ready;
   logic [BLW-1:0]  burst_len;
   logic [LW-1:0]   seed_in;
   logic [DW-1:0]   out_data;
   logic            out_valid, empty, full, busy, done;
   logic [PW-1:0]   level;

   always #5 clk = ~clk;

   prng_fifo_streamer dut (
      .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .stop(stop),
      .burst_len(burst_len), .seed_load(seed_load), .seed_in(seed_in), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .empty(empty), .full(full), .busy(busy), .done(done)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit           m_active;
   int           m_left;      // words still to generate, -1 = unlimited
   logic [LW-1:0] m_lfsr;
   logic [DW-1:0] q[$];
   bit           m_done;

   typedef struct {
      logic [LW-1:0]  seed;
      logic [1:0]     md;
      logic [BLW-1:0] blen;
      int             exp_level;
      int             exp_first;
      int             exp_dones;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One generated word from the reference LFSR, straight from the stepping rule.
   task automatic ref_word(output logic [DW-1:0] w);
      logic o;
      w = '0;
      for (int i = 0; i < DW; i++) begin
         o = m_lfsr[0];
         w[i] = o;
         m_lfsr = (m_lfsr >> 1) ^ (o ? 8'hB8 : 8'h00);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_left   = 0;
      m_lfsr   = 8'h01;
      m_done   = 1'b0;
      q.delete();
   endtask

   task automatic model_edge();
      bit gen, pop;
      logic [DW-1:0] w;
      gen = m_active && (q.size() < DEPTH) && !flush;
      pop = (q.size() > 0) && out_ready && !flush;
      m_done = 1'b0;
      if (flush) q.delete();
      else if (pop) void'(q.pop_front());
      if (gen) begin
         ref_word(w);
         q.push_back(w);
      end else if (!m_active && seed_load) begin
         m_lfsr = (seed_in == 8'h00) ? 8'h01 : seed_in;
      end
      if (stop) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (start && mode == 2'd0) begin m_active = 1'b1; m_left = 1; end
         if (start && mode == 2'd1 && burst_len != 4'd0) begin m_active = 1'b1; m_left = int'(burst_len); end
         if (start && mode == 2'd2) begin m_active = 1'b1; m_left = -1; end
      end else if (gen && m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", int'(out_valid), int'(q.size() > 0));
      chk("level", int'(level), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("busy", int'(busy), int'(m_active));
      chk("done", int'(done), int'(m_done));
      if (q.size() > 0) chk("out_data", int'(out_data), int'(q[0]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic quiet();
      start = 1'b0; stop = 1'b0; seed_load = 1'b0; flush = 1'b0;
   endtask

   // Reset asserted away from the clock edge; outputs must drop immediately.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic kick(input logic [1:0] md, input logic [BLW-1:0] bl);
      mode = md; burst_len = bl; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int dcount;
      reset_n = 1'b0; quiet(); mode = 2'd0; burst_len = 4'd0; seed_in = 8'h00; out_ready = 1'b0;
      tbl[0] = '{8'h00, 2'd0, 4'd0, 1, 4'h1, 1};
      tbl[1] = '{8'h01, 2'd1, 4'd5, 5, 4'h1, 1};
      tbl[2] = '{8'h17, 2'd0, 4'd3, 1, 4'h7, 1};
      tbl[3] = '{8'h64, 2'd0, 4'd0, 1, 4'h4, 1};
      tbl[4] = '{8'h01, 2'd3, 4'd5, 0, 4'h0, 0};
      tbl[5] = '{8'h01, 2'd1, 4'd0, 0, 4'h0, 0};
      #12;
      model_reset();
      check_outputs();
      @(negedge clk) reset_n = 1'b1;

      // table: reseed together with start, then let it settle with no consumer
      for (int r = 0; r < 6; r++) begin
         do_reset();
         seed_load = 1'b1; seed_in = tbl[r].seed;
         kick(tbl[r].md, tbl[r].blen);
         seed_load = 1'b0;
         dcount = 0;
         for (int c = 0; c < 20; c++) begin
            step();
            dcount += int'(done);
         end
         chk("tbl_level", int'(level), tbl[r].exp_level);
         chk("tbl_dones", dcount, tbl[r].exp_dones);
         chk("tbl_busy", int'(busy), 0);
         if (tbl[r].exp_level > 0) chk("tbl_first", int'(out_data), tbl[r].exp_first);
      end

      // two singles: 0x1 then 0x7
      do_reset();
      kick(2'd0, 4'd0);
      step();
      chk("single1_data", int'(out_data), 1);
      chk("single1_done", int'(done), 1);
      kick(2'd0, 4'd0);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single2_data", int'(out_data), 7);

      // continuous to full, single pop, refill, stop without done
      do_reset();
      kick(2'd2, 4'd0);
      repeat (20) step();
      chk("cont_full", int'(full), 1);
      chk("cont_level", int'(level), 16);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop_level", int'(level), 15);
      step();
      chk("refill_full", int'(full), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_done", int'(done), 0);

      // continuous with steady consumer: level pinned at 1
      do_reset();
      out_ready = 1'b1;
      kick(2'd2, 4'd0);
      for (int c = 0; c < 10; c++) begin
         step();
         chk("stream_level", int'(level), 1);
      end
      seed_load = 1'b1; seed_in = 8'h55;
      step();
      seed_load = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      out_ready = 1'b0;

      // flush at level 9 while continuous
      do_reset();
      kick(2'd2, 4'd0);
      repeat (9) step();
      chk("pre_flush_level", int'(level), 9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_level", int'(level), 0);
      chk("flush_empty", int'(empty), 1);
      step();
      chk("resume_level", int'(level), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;

      // reseed to zero becomes 1; reset in the middle of a burst
      do_reset();
      seed_load = 1'b1; seed_in = 8'h00;
      step();
      seed_load = 1'b0;
      kick(2'd0, 4'd0);
      step();
      chk("seed0_data", int'(out_data), 1);
      kick(2'd1, 4'd8);
      repeat (3) step();
      do_reset();
      chk("midreset_level", int'(level), 0);
      chk("midreset_busy", int'(busy), 0);

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         start     = ($urandom_range(0, 7) == 0);
         mode      = 2'($urandom_range(0, 3));
         burst_len = 4'($urandom_range(0, 15));
         stop      = ($urandom_range(0, 29) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         seed_load = ($urandom_range(0, 9) == 0);
         seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step();
      end
      quiet();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
